// File: rtl/serial_word_divisibility_feeder.sv
// Serialises WIDTH-bit words MSB-first into a serial divisibility checker,
// clears the checker between words and returns each word with its verdict.
module serial_word_divisibility_feeder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             chk_clear,
    output logic             new_bit,
    input  logic             div_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_div,
    input  logic             out_ready
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CAPT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_div_q, out_div_d;
    logic             chk_clear_q, chk_clear_d;
    logic             new_bit_q, new_bit_d;
    logic             accept;

    // Next-state, datapath and checker-drive decode
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        word_d      = word_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_div_d   = out_div_q;
        in_ready    = 1'b0;
        accept      = 1'b0;

        case (state_q)
            IDLE: begin
                // Only accept when the result register is empty or draining now
                in_ready = rst && (!out_valid_q || out_ready);
                accept   = in_valid && in_ready;
                if (accept) begin
                    shift_d   = in_data;
                    word_d    = in_data;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shift_d   = shift_q << 1;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                // Checker now holds the remainder of the whole word
                out_valid_d = 1'b1;
                out_data_d  = word_q;
                out_div_d   = div_in;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Checker is held clear in every cycle that does not carry a data bit
        chk_clear_d = (state_d != SHIFT);
        new_bit_d   = (state_d == SHIFT) ? shift_d[WIDTH-1] : 1'b0;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            word_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_div_q   <= 1'b0;
            chk_clear_q <= 1'b1;
            new_bit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            word_q      <= word_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_div_q   <= out_div_d;
            chk_clear_q <= chk_clear_d;
            new_bit_q   <= new_bit_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_div   = out_div_q;
    assign chk_clear = chk_clear_q;
    assign new_bit   = new_bit_q;

endmodule
